// File: rtl/controle_pilha_if.sv
// Bus between the stack controller, its requester, the data memory and the
// register bank that holds $rp.
interface controle_pilha_if;
    logic        push;
    logic        pop;
    logic [31:0] dado_in;
    logic [31:0] mem_dado_in;
    logic [31:0] mem_addr;
    logic [31:0] mem_dado_out;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] rp_novo;
    logic        PilhaE;
    logic [31:0] dado_out;
    logic        dado_valido;
    logic        ocupado;
    logic        overflow;
    logic        underflow;
    logic [3:0]  profundidade;

    modport slave (
        input  push, pop, dado_in, mem_dado_in,
        output mem_addr, mem_dado_out, MemWrite, MemRead, rp_novo, PilhaE,
        output dado_out, dado_valido, ocupado, overflow, underflow, profundidade
    );

    modport master (
        output push, pop, dado_in, mem_dado_in,
        input  mem_addr, mem_dado_out, MemWrite, MemRead, rp_novo, PilhaE,
        input  dado_out, dado_valido, ocupado, overflow, underflow, profundidade
    );
endinterface

// File: rtl/controle_pilha.sv
// Hardware stack controller: keeps a shadow $rp, drives memory accesses for
// push/pop and publishes the updated $rp to the register bank.
module controle_pilha #(
    parameter int unsigned TOPO   = 25,
    parameter int unsigned LIMITE = 17
) (
    input logic                  clock,
    input logic                  reset,
    controle_pilha_if.slave      bus
);
    localparam logic [31:0] TOPO_W   = 32'(TOPO);
    localparam logic [31:0] LIMITE_W = 32'(LIMITE);

    typedef enum logic [1:0] {
        OCIOSO     = 2'd0,
        PUSH_ESCR  = 2'd1,
        POP_LER    = 2'd2,
        POP_ESPERA = 2'd3
    } estado_t;

    estado_t     estado_q, estado_d;
    logic [31:0] rp_q, rp_d;
    logic [31:0] dado_lat_q, dado_lat_d;
    logic [31:0] dado_out_q, dado_out_d;
    logic        dado_valido_q, dado_valido_d;
    logic        overflow_q, overflow_d;
    logic        underflow_q, underflow_d;

    // State, pointer and result registers; reset drops any pending push word.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q      <= OCIOSO;
            rp_q          <= TOPO_W;
            dado_lat_q    <= 32'd0;
            dado_out_q    <= 32'd0;
            dado_valido_q <= 1'b0;
            overflow_q    <= 1'b0;
            underflow_q   <= 1'b0;
        end else begin
            estado_q      <= estado_d;
            rp_q          <= rp_d;
            dado_lat_q    <= dado_lat_d;
            dado_out_q    <= dado_out_d;
            dado_valido_q <= dado_valido_d;
            overflow_q    <= overflow_d;
            underflow_q   <= underflow_d;
        end
    end

    // Next-state logic; push has priority over pop and rejected requests only flag.
    always_comb begin
        estado_d      = estado_q;
        rp_d          = rp_q;
        dado_lat_d    = dado_lat_q;
        dado_out_d    = dado_out_q;
        dado_valido_d = 1'b0;
        overflow_d    = 1'b0;
        underflow_d   = 1'b0;
        case (estado_q)
            OCIOSO: begin
                if (bus.push) begin
                    if (rp_q != LIMITE_W) begin
                        dado_lat_d = bus.dado_in;
                        estado_d   = PUSH_ESCR;
                    end else begin
                        overflow_d = 1'b1;
                    end
                end else if (bus.pop) begin
                    if (rp_q != TOPO_W) begin
                        estado_d = POP_LER;
                    end else begin
                        underflow_d = 1'b1;
                    end
                end else begin
                    estado_d = OCIOSO;
                end
            end
            PUSH_ESCR: begin
                rp_d     = rp_q - 32'd1;
                estado_d = OCIOSO;
            end
            POP_LER: begin
                estado_d = POP_ESPERA;
            end
            POP_ESPERA: begin
                dado_out_d    = bus.mem_dado_in;
                dado_valido_d = 1'b1;
                rp_d          = rp_q + 32'd1;
                estado_d      = OCIOSO;
            end
            default: begin
                estado_d = OCIOSO;
            end
        endcase
    end

    // Output decode from state and pointer only.
    always_comb begin
        bus.mem_addr     = rp_q;
        bus.mem_dado_out = dado_lat_q;
        bus.MemWrite     = 1'b0;
        bus.MemRead      = 1'b0;
        bus.PilhaE       = 1'b0;
        bus.rp_novo      = rp_q;
        bus.ocupado      = 1'b1;
        case (estado_q)
            OCIOSO: begin
                bus.ocupado = 1'b0;
            end
            PUSH_ESCR: begin
                bus.mem_addr = rp_q - 32'd1;
                bus.MemWrite = 1'b1;
                bus.PilhaE   = 1'b1;
                bus.rp_novo  = rp_q - 32'd1;
            end
            POP_LER: begin
                bus.MemRead = 1'b1;
            end
            POP_ESPERA: begin
                bus.PilhaE  = 1'b1;
                bus.rp_novo = rp_q + 32'd1;
            end
            default: begin
                bus.ocupado = 1'b0;
            end
        endcase
    end

    assign bus.dado_out     = dado_out_q;
    assign bus.dado_valido  = dado_valido_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
    assign bus.profundidade = 4'(TOPO_W - rp_q);
endmodule

// File: tb/tb_controle_pilha.sv
// Directed bench for controle_pilha with a registered-read data memory model.
module tb_controle_pilha;
    logic clock;
    logic reset;
    int   pass_cnt;
    int   total_cnt;
    logic [31:0] mem [0:31];

    controle_pilha_if bus();

    controle_pilha #(.TOPO(25), .LIMITE(17)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory: write on MemWrite, read data valid the cycle after MemRead.
    always @(posedge clock) begin
        if (bus.MemWrite) mem[bus.mem_addr[4:0]] <= bus.mem_dado_out;
        if (bus.MemRead) bus.mem_dado_in <= mem[bus.mem_addr[4:0]];
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.push = 1'b0;
        bus.pop = 1'b0;
        bus.dado_in = 32'd0;
        bus.mem_dado_in = 32'd0;
        repeat (2) tick();
        reset = 1'b0;
        tick();
        total_cnt++;
        if (bus.rp_novo !== 32'd25) $display("FAIL reset_rp_novo got %0d want 25", bus.rp_novo);
        else pass_cnt++;
        total_cnt++;
        if (bus.profundidade !== 4'd0) $display("FAIL reset_prof got %0d want 0", bus.profundidade);
        else pass_cnt++;
        total_cnt++;
        if ({bus.ocupado, bus.PilhaE, bus.MemWrite, bus.MemRead, bus.dado_valido} !== 5'b0)
            $display("FAIL reset_strobes got %b want 00000",
                     {bus.ocupado, bus.PilhaE, bus.MemWrite, bus.MemRead, bus.dado_valido});
        else pass_cnt++;
        total_cnt++;
        if (bus.dado_out !== 32'd0) $display("FAIL reset_dado_out got %h want 0", bus.dado_out);
        else pass_cnt++;
    endtask

    task automatic test_push_basic();
        bus.push = 1'b1;
        bus.dado_in = 32'hAAAA5555;
        tick();
        bus.push = 1'b0;
        bus.dado_in = 32'h0;
        total_cnt++;
        if ({bus.MemWrite, bus.PilhaE, bus.ocupado} !== 3'b111)
            $display("FAIL push_strobes got %b want 111", {bus.MemWrite, bus.PilhaE, bus.ocupado});
        else pass_cnt++;
        total_cnt++;
        if (bus.mem_addr !== 32'd24) $display("FAIL push_addr got %0d want 24", bus.mem_addr);
        else pass_cnt++;
        total_cnt++;
        if (bus.mem_dado_out !== 32'hAAAA5555) $display("FAIL push_data got %h want aaaa5555", bus.mem_dado_out);
        else pass_cnt++;
        total_cnt++;
        if (bus.rp_novo !== 32'd24) $display("FAIL push_rp_novo got %0d want 24", bus.rp_novo);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (bus.profundidade !== 4'd1) $display("FAIL push_prof got %0d want 1", bus.profundidade);
        else pass_cnt++;
        total_cnt++;
        if ({bus.MemWrite, bus.PilhaE, bus.ocupado} !== 3'b000)
            $display("FAIL push_done got %b want 000", {bus.MemWrite, bus.PilhaE, bus.ocupado});
        else pass_cnt++;
        total_cnt++;
        if (bus.mem_addr !== 32'd24) $display("FAIL push_idle_addr got %0d want 24", bus.mem_addr);
        else pass_cnt++;
    endtask

    task automatic test_pop_basic();
        bus.pop = 1'b1;
        tick();
        bus.pop = 1'b0;
        total_cnt++;
        if (bus.MemRead !== 1'b1 || bus.mem_addr !== 32'd24 || bus.PilhaE !== 1'b0)
            $display("FAIL pop_ler got rd=%b addr=%0d pe=%b want 1 24 0", bus.MemRead, bus.mem_addr, bus.PilhaE);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (bus.PilhaE !== 1'b1 || bus.rp_novo !== 32'd25 || bus.MemRead !== 1'b0 || bus.dado_valido !== 1'b0)
            $display("FAIL pop_espera got pe=%b rp=%0d rd=%b dv=%b want 1 25 0 0",
                     bus.PilhaE, bus.rp_novo, bus.MemRead, bus.dado_valido);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (bus.dado_valido !== 1'b1 || bus.dado_out !== 32'hAAAA5555)
            $display("FAIL pop_result got dv=%b data=%h want 1 aaaa5555", bus.dado_valido, bus.dado_out);
        else pass_cnt++;
        total_cnt++;
        if (bus.profundidade !== 4'd0 || bus.rp_novo !== 32'd25 || bus.ocupado !== 1'b0)
            $display("FAIL pop_prof got prof=%0d rp=%0d oc=%b want 0 25 0", bus.profundidade, bus.rp_novo, bus.ocupado);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (bus.dado_valido !== 1'b0 || bus.dado_out !== 32'hAAAA5555)
            $display("FAIL pop_hold got dv=%b data=%h want 0 aaaa5555", bus.dado_valido, bus.dado_out);
        else pass_cnt++;
    endtask

    task automatic test_underflow();
        bus.pop = 1'b1;
        tick();
        bus.pop = 1'b0;
        total_cnt++;
        if (bus.underflow !== 1'b1 || bus.MemRead !== 1'b0 || bus.ocupado !== 1'b0 || bus.rp_novo !== 32'd25)
            $display("FAIL underflow_pulse got uf=%b rd=%b oc=%b rp=%0d want 1 0 0 25",
                     bus.underflow, bus.MemRead, bus.ocupado, bus.rp_novo);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (bus.underflow !== 1'b0 || bus.MemRead !== 1'b0)
            $display("FAIL underflow_clear got uf=%b rd=%b want 0 0", bus.underflow, bus.MemRead);
        else pass_cnt++;
    endtask

    task automatic test_overflow_fill_drain();
        for (int i = 1; i <= 8; i++) begin
            bus.push = 1'b1;
            bus.dado_in = 32'(i);
            tick();
            bus.push = 1'b0;
            total_cnt++;
            if (bus.MemWrite !== 1'b1 || bus.mem_addr !== 32'(25 - i))
                $display("FAIL fill_write_%0d got wr=%b addr=%0d want 1 %0d", i, bus.MemWrite, bus.mem_addr, 25 - i);
            else pass_cnt++;
            tick();
        end
        total_cnt++;
        if (bus.profundidade !== 4'd8 || bus.rp_novo !== 32'd17)
            $display("FAIL full_state got prof=%0d rp=%0d want 8 17", bus.profundidade, bus.rp_novo);
        else pass_cnt++;
        bus.push = 1'b1;
        bus.dado_in = 32'd9;
        tick();
        bus.push = 1'b0;
        total_cnt++;
        if (bus.overflow !== 1'b1 || bus.MemWrite !== 1'b0 || bus.PilhaE !== 1'b0 || bus.rp_novo !== 32'd17)
            $display("FAIL overflow_pulse got of=%b wr=%b pe=%b rp=%0d want 1 0 0 17",
                     bus.overflow, bus.MemWrite, bus.PilhaE, bus.rp_novo);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (bus.overflow !== 1'b0 || bus.profundidade !== 4'd8)
            $display("FAIL overflow_clear got of=%b prof=%0d want 0 8", bus.overflow, bus.profundidade);
        else pass_cnt++;
        for (int i = 0; i < 8; i++) begin
            bus.pop = 1'b1;
            tick();
            bus.pop = 1'b0;
            tick();
            tick();
            total_cnt++;
            if (bus.dado_valido !== 1'b1 || bus.dado_out !== 32'(8 - i))
                $display("FAIL drain_%0d got dv=%b data=%0d want 1 %0d", i, bus.dado_valido, bus.dado_out, 8 - i);
            else pass_cnt++;
        end
        total_cnt++;
        if (bus.profundidade !== 4'd0 || bus.rp_novo !== 32'd25)
            $display("FAIL drained_state got prof=%0d rp=%0d want 0 25", bus.profundidade, bus.rp_novo);
        else pass_cnt++;
    endtask

    task automatic test_push_pop_together();
        bus.push = 1'b1;
        bus.pop = 1'b1;
        bus.dado_in = 32'h1234_5678;
        tick();
        bus.push = 1'b0;
        bus.pop = 1'b0;
        total_cnt++;
        if (bus.MemWrite !== 1'b1 || bus.MemRead !== 1'b0 || bus.mem_addr !== 32'd24)
            $display("FAIL both_push_wins got wr=%b rd=%b addr=%0d want 1 0 24", bus.MemWrite, bus.MemRead, bus.mem_addr);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (bus.ocupado !== 1'b0 || bus.MemRead !== 1'b0 || bus.profundidade !== 4'd1)
            $display("FAIL both_pop_dropped got oc=%b rd=%b prof=%0d want 0 0 1", bus.ocupado, bus.MemRead, bus.profundidade);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (bus.ocupado !== 1'b0 || bus.MemRead !== 1'b0)
            $display("FAIL both_no_late_pop got oc=%b rd=%b want 0 0", bus.ocupado, bus.MemRead);
        else pass_cnt++;
    endtask

    task automatic test_reset_in_pop_ler();
        bus.pop = 1'b1;
        tick();
        bus.pop = 1'b0;
        total_cnt++;
        if (bus.MemRead !== 1'b1) $display("FAIL rst_pop_ler got rd=%b want 1", bus.MemRead);
        else pass_cnt++;
        reset = 1'b1;
        #1;
        total_cnt++;
        if (bus.MemRead !== 1'b0 || bus.ocupado !== 1'b0 || bus.rp_novo !== 32'd25 || bus.profundidade !== 4'd0)
            $display("FAIL rst_async got rd=%b oc=%b rp=%0d prof=%0d want 0 0 25 0",
                     bus.MemRead, bus.ocupado, bus.rp_novo, bus.profundidade);
        else pass_cnt++;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            total_cnt++;
            if (bus.dado_valido !== 1'b0 || bus.PilhaE !== 1'b0 || bus.rp_novo !== 32'd25)
                $display("FAIL rst_quiet_%0d got dv=%b pe=%b rp=%0d want 0 0 25", i, bus.dado_valido, bus.PilhaE, bus.rp_novo);
            else pass_cnt++;
        end
    endtask

    initial begin
        pass_cnt = 0;
        total_cnt = 0;
        test_reset();
        test_push_basic();
        test_pop_basic();
        test_underflow();
        test_overflow_fill_drain();
        test_push_pop_together();
        test_reset_in_pop_ler();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/controle_pilha.md
CONTROLE_PILHA -- requirements
Module: controle_pilha

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- TOPO 25: empty-stack value of $rp.
- LIMITE 17: full-stack value of $rp; depth = TOPO-LIMITE = 8 words.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clock in 1: single clock; all state changes on posedge.
- reset in 1: asynchronous, active-high.
- push in 1: push request.
- pop in 1: pop request.
- dado_in in 32: word to push; sampled when a push is accepted.
- mem_dado_in in 32: data-memory read data, valid the cycle after MemRead.
- mem_addr out 32: data-memory address.
- mem_dado_out out 32: data-memory write data.
- MemWrite out 1: memory write strobe.
- MemRead out 1: memory read strobe.
- rp_novo out 32: new $rp value for the register bank.
- PilhaE out 1: register-bank $rp write enable.
- dado_out out 32: popped word.
- dado_valido out 1: dado_out valid strobe.
- ocupado out 1: operation in progress.
- overflow out 1: push rejected because the stack is full.
- underflow out 1: pop rejected because the stack is empty.
- profundidade out 4: current number of stacked words.

Function
REQ-003 The block SHALL keep an internal 32-bit shadow $rp (rp_reg), the only source of the stack pointer; the stack grows downward from TOPO toward LIMITE.
REQ-004 The FSM SHALL have states OCIOSO, PUSH_ESCR, POP_LER and POP_ESPERA; all outputs except dado_out SHALL decode from state and rp_reg only.
REQ-005 In OCIOSO: ocupado=0; a request SHALL be accepted only in this state, on the posedge where it is sampled high.
REQ-006 OCIOSO, push=1, rp_reg != LIMITE:
- latch dado_in;
- next state PUSH_ESCR.
REQ-007 OCIOSO, push=1, rp_reg == LIMITE:
- overflow=1 for exactly the next cycle;
- no memory or bank write;
- stay in OCIOSO.
REQ-008 OCIOSO, pop=1, push=0, rp_reg != TOPO: next state POP_LER.
REQ-009 OCIOSO, pop=1, push=0, rp_reg == TOPO:
- underflow=1 for exactly the next cycle;
- no memory access;
- stay in OCIOSO.
REQ-010 If push and pop are both high in OCIOSO, push SHALL win and pop SHALL be discarded, not queued.
REQ-011 PUSH_ESCR (1 cycle):
- mem_addr=rp_reg-1; mem_dado_out=latched word;
- MemWrite=1; PilhaE=1; rp_novo=rp_reg-1; ocupado=1;
- at cycle end rp_reg<=rp_reg-1; next state OCIOSO.
REQ-012 POP_LER (1 cycle):
- mem_addr=rp_reg; MemRead=1; ocupado=1;
- next state POP_ESPERA.
REQ-013 POP_ESPERA (1 cycle):
- ocupado=1; PilhaE=1; rp_novo=rp_reg+1;
- at cycle end dado_out<=mem_dado_in, rp_reg<=rp_reg+1;
- next state OCIOSO.
REQ-014 dado_valido SHALL be 1 for exactly the cycle after POP_ESPERA; dado_out SHALL hold its value until the next pop completes.
REQ-015 Push latency SHALL be 1 cycle (acceptance to MemWrite); pop latency SHALL be 3 cycles (acceptance to dado_valido).
REQ-016 Requests while ocupado=1 SHALL be ignored with no flag raised; the requester SHALL hold or reissue them.
REQ-017 Outside PUSH_ESCR/POP_ESPERA:
- PilhaE=0; MemWrite=0;
- rp_novo=rp_reg.
REQ-018 Outside MemRead/MemWrite cycles, mem_addr SHALL equal rp_reg.
REQ-019 profundidade SHALL equal TOPO-rp_reg (4 bits), updated the same edge as rp_reg.
REQ-020 Address arithmetic SHALL be 32-bit unsigned; rp_reg SHALL never leave [LIMITE, TOPO].

Reset
REQ-021 On reset, asynchronously and regardless of state:
- FSM = OCIOSO; rp_reg = TOPO; rp_novo = 25;
- dado_out = 0; profundidade = 0;
- all strobes/flags (MemWrite, MemRead, PilhaE, dado_valido, ocupado, overflow, underflow) = 0.
REQ-022 Reset during any state SHALL abort the operation: no write or strobe SHALL be issued after reset asserts, and the latched push word SHALL be discarded.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Reset release -> rp_novo=25, profundidade=0, ocupado=0, PilhaE=0.
- push with dado_in=0xAAAA5555 -> next cycle MemWrite=1, mem_addr=24, mem_dado_out=0xAAAA5555, PilhaE=1, rp_novo=24; then profundidade=1.
- pop after that push, memory model returns 0xAAAA5555 -> MemRead at addr 24, dado_valido 3 cycles after acceptance with dado_out=0xAAAA5555, rp_novo=25, profundidade=0.
- pop on empty stack -> underflow pulses one cycle, no MemRead, rp_novo stays 25.
- 8 pushes of values 1..8, then a 9th push -> overflow pulses one cycle, rp_novo=17, no MemWrite; 8 pops return 8..1.
- push and pop high together -> only push executes; reset asserted in POP_LER -> no dado_valido/PilhaE follow, rp_novo returns to 25.
